display_scan_capture: RTL and testbench
=======================================

// Module: display_scan_capture
// PURPOSE
//   Receive-side monitor for the multiplexed 4-digit 7-segment display bus.
//   Watches active-low anode selects and segment lines, as the digit-select sequencer
//   drives them, and rebuilds the four displayed hex digits. Also flags illegal scan
//   patterns and segment codes.
//   Sits beside the display pins: on-chip self-check, and as a bench model for scan logic.
// PARAMETERS
//   SETTLE_CYCLES   1     consecutive cycles an/seg/dp must be unchanged before capture (>=1)
//   TIMEOUT_CYCLES  1024  cycles without any capture before outputs are declared stale (>=2)
// PORTS
//   clk          in   1   system clock; sole clock domain
//   rst          in   1   synchronous, active-high reset
//   an           in   4   anode selects, active-low; an[0]=units ... an[3]=thousands
//   seg          in   7   segments, active-low; seg[0]=a ... seg[6]=g
//   dp           in   1   decimal point, active-low
//   digits       out  16  captured hex; digits[4i+3:4i] = digit i
//   digit_valid  out  4   1 = digit i holds a legal code captured since reset/stale
//   digit_blank  out  4   1 = digit i last captured all-off (seg=7'h7F)
//   dp_lit       out  4   1 = dp of digit i lit at last capture
//   frame_done   out  1   1-cycle pulse: all four digits captured since previous pulse
//   scan_error   out  1   1-cycle pulse: >1 anode low in a settled pattern
//   seg_error    out  1   1-cycle pulse: settled segment code not in decode table
//   stale        out  1   level: no capture for TIMEOUT_CYCLES cycles
// BEHAVIOUR
//   Reset: all outputs 0; input regs <= an=4'hF, seg=7'h7F, dp=1; counters 0; mask 0.
//   Input stage: an/seg/dp registered every cycle (edge E0).
//   Stability: stab_cnt clears when registered {an,seg,dp} differs from previous cycle,
//     else increments (saturating); 'settled' when SETTLE_CYCLES cycles equal.
//   One capture per dwell: done_flag set on capture, cleared on any input change.
//   Latency: pattern on pins before edge E0 -> outputs/pulses update at edge
//     E0+SETTLE_CYCLES (E0+1 for default), so 1-cycle dwells are captured.
//   Decision when settled and !done_flag, by registered an:
//     4'b1111            -> no digit active; no action, no error
//     exactly one 0 at i -> capture digit i (below)
//     two or more 0s     -> scan_error pulse; no capture
//   Capture of digit i: dp_lit[i] <= ~dp; mask[i] <= 1; timeout counter cleared.
//     seg in table       -> digits[i] <= code, digit_valid[i]<=1, digit_blank[i]<=0
//     seg == 7'h7F       -> digit_blank[i]<=1, digit_valid[i]<=0, digits[i] held
//     otherwise          -> seg_error pulse, digit_valid[i]<=0, blank[i]<=0, digits held
//   Decode table (seg hex, active-low gfedcba): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
//     8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E; exact match only.
//   Frame: when mask incl. this capture == 4'hF -> frame_done pulse same edge, mask <= 0.
//     Repeat capture of same digit before frame completes: overwrite, no error.
//   Timeout: counter increments each cycle with no capture (saturating); reaching
//     TIMEOUT_CYCLES -> stale<=1, digit_valid<=0, mask<=0. Next capture clears stale
//     on same edge as its update.
//   Simultaneous: capture and timeout same edge -> capture wins (stale stays 0).
//   rst mid-dwell: everything to reset values; next dwell waits full settle time.
// TESTING
//   Rotate an 1110,1101,1011,0111 one cycle each, seg 40,79,24,30 -> digits=16'h3210,
//     digit_valid=4'hF, frame_done pulse at edge after 4th dwell (+SETTLE latency).
//   Hold an=1110 seg=02 for 50 cycles -> exactly one capture, digits[3:0]=6, no
//     frame_done, seg_error/scan_error stay 0.
//   an=1100 settled -> one scan_error pulse, digits/valid unchanged; an=1111 -> no pulse.
//   Digit 2 seg=7'h55 -> seg_error pulse, digit_valid[2]=0; seg=7'h7F -> digit_blank[2]=1.
//   Stop scanning (an=1111) TIMEOUT_CYCLES cycles -> stale=1, digit_valid=0; resume
//     -> stale clears on first capture.
//   Assert rst mid-frame with dp=0 -> all outputs 0 next edge; SETTLE_CYCLES=3 build:
//     2-cycle glitch on an ignored, 3-cycle dwell captured.

Source files
------------

// File: rtl/display_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_capture
// Description : Receive-side monitor for a multiplexed 4-digit 7-segment bus.
//               Rebuilds the displayed hex digits from active-low anode and
//               segment lines, and flags illegal scan patterns / segment codes.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_capture #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_blank,
    output logic [3:0]  dp_lit,
    output logic        frame_done,
    output logic        scan_error,
    output logic        seg_error,
    output logic        stale
);

    localparam int c_SW = $clog2(SETTLE_CYCLES + 1) + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [c_SW-1:0] c_SETTLE_MAX  = c_SW'(SETTLE_CYCLES);
    localparam logic [c_TW-1:0] c_TIMEOUT_MAX = c_TW'(TIMEOUT_CYCLES);

    logic [3:0]      r_an;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic [11:0]     r_prev;
    logic [c_SW-1:0] r_stab;
    logic            r_done;
    logic [3:0]      r_mask;
    logic [c_TW-1:0] r_to;

    logic [15:0]     r_digits;
    logic [3:0]      r_valid;
    logic [3:0]      r_blank;
    logic [3:0]      r_dp_lit;
    logic            r_frame_done;
    logic            r_scan_error;
    logic            r_seg_error;
    logic            r_stale;

    logic            w_change;
    logic [c_SW-1:0] w_stab;
    logic            w_act;
    logic [1:0]      w_idx;
    logic            w_one;
    logic            w_multi;
    logic            w_capture;
    logic            w_hit;
    logic [3:0]      w_code;
    logic [3:0]      w_mask_new;
    logic [c_TW-1:0] w_to_next;
    logic            w_timeout;

    // Input stage: register the pins every cycle and keep last cycle's copy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an   <= 4'hF;
            r_seg  <= 7'h7F;
            r_dp   <= 1'b1;
            r_prev <= {4'hF, 7'h7F, 1'b1};
        end else begin
            r_an   <= an;
            r_seg  <= seg;
            r_dp   <= dp;
            r_prev <= {r_an, r_seg, r_dp};
        end
    end

    // Stability tracking: count includes the current cycle, so a pattern is
    // acted on in the very cycle it reaches SETTLE_CYCLES of equality
    always_comb begin
        w_change = ({r_an, r_seg, r_dp} != r_prev);
        if (w_change)
            w_stab = c_SW'(1);
        else if (r_stab >= c_SETTLE_MAX)
            w_stab = c_SETTLE_MAX;
        else
            w_stab = r_stab + c_SW'(1);
        w_act = (w_stab >= c_SETTLE_MAX) && !(r_done && !w_change);
    end

    // Anode classification: idle, single digit selected, or illegal overlap
    always_comb begin
        w_idx   = 2'd0;
        w_one   = 1'b0;
        w_multi = 1'b0;
        case (r_an)
            4'b1110: begin w_idx = 2'd0; w_one = 1'b1; end
            4'b1101: begin w_idx = 2'd1; w_one = 1'b1; end
            4'b1011: begin w_idx = 2'd2; w_one = 1'b1; end
            4'b0111: begin w_idx = 2'd3; w_one = 1'b1; end
            4'b1111: ;
            default: w_multi = 1'b1;
        endcase
    end

    // Segment decode: exact match against the active-low hex font only
    always_comb begin
        w_hit  = 1'b1;
        w_code = 4'h0;
        case (r_seg)
            7'h40: w_code = 4'h0;
            7'h79: w_code = 4'h1;
            7'h24: w_code = 4'h2;
            7'h30: w_code = 4'h3;
            7'h19: w_code = 4'h4;
            7'h12: w_code = 4'h5;
            7'h02: w_code = 4'h6;
            7'h78: w_code = 4'h7;
            7'h00: w_code = 4'h8;
            7'h10: w_code = 4'h9;
            7'h08: w_code = 4'hA;
            7'h03: w_code = 4'hB;
            7'h46: w_code = 4'hC;
            7'h21: w_code = 4'hD;
            7'h06: w_code = 4'hE;
            7'h0E: w_code = 4'hF;
            default: w_hit = 1'b0;
        endcase
    end

    // Capture, frame-mask and timeout bookkeeping
    always_comb begin
        w_capture  = w_act && w_one;
        w_mask_new = r_mask | ~r_an;
        if (w_capture)
            w_to_next = '0;
        else if (r_to == c_TIMEOUT_MAX)
            w_to_next = r_to;
        else
            w_to_next = r_to + c_TW'(1);
        w_timeout = !w_capture && (w_to_next == c_TIMEOUT_MAX);
    end

    // Output state: pulses default low; a capture always takes priority over timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stab       <= '0;
            r_done       <= 1'b0;
            r_mask       <= 4'h0;
            r_to         <= '0;
            r_digits     <= 16'h0000;
            r_valid      <= 4'h0;
            r_blank      <= 4'h0;
            r_dp_lit     <= 4'h0;
            r_frame_done <= 1'b0;
            r_scan_error <= 1'b0;
            r_seg_error  <= 1'b0;
            r_stale      <= 1'b0;
        end else begin
            r_stab       <= w_stab;
            r_done       <= (r_done && !w_change) || w_act;
            r_to         <= w_to_next;
            r_frame_done <= 1'b0;
            r_scan_error <= w_act && w_multi;
            r_seg_error  <= 1'b0;
            if (w_capture) begin
                r_dp_lit[w_idx] <= ~r_dp;
                r_stale         <= 1'b0;
                if (w_hit) begin
                    r_digits[{w_idx, 2'b00} +: 4] <= w_code;
                    r_valid[w_idx] <= 1'b1;
                    r_blank[w_idx] <= 1'b0;
                end else if (r_seg == 7'h7F) begin
                    r_valid[w_idx] <= 1'b0;
                    r_blank[w_idx] <= 1'b1;
                end else begin
                    r_seg_error    <= 1'b1;
                    r_valid[w_idx] <= 1'b0;
                    r_blank[w_idx] <= 1'b0;
                end
                if (w_mask_new == 4'hF) begin
                    r_frame_done <= 1'b1;
                    r_mask       <= 4'h0;
                end else begin
                    r_mask <= w_mask_new;
                end
            end else if (w_timeout) begin
                r_stale <= 1'b1;
                r_valid <= 4'h0;
                r_mask  <= 4'h0;
            end
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign digit_blank = r_blank;
    assign dp_lit      = r_dp_lit;
    assign frame_done  = r_frame_done;
    assign scan_error  = r_scan_error;
    assign seg_error   = r_seg_error;
    assign stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_capture
// Description : Directed self-checking bench for display_scan_capture, with a
//               default build and a SETTLE_CYCLES=3 build sharing the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_capture;

    logic        clk;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [15:0] digits1, digits3;
    logic [3:0]  valid1, valid3, blank1, blank3, dpl1, dpl3;
    logic        frame1, frame3, scan1, scan3, segerr1, segerr3, stale1, stale3;

    int n_checks = 0;
    int n_fail   = 0;
    int n_frame  = 0;
    int n_scan   = 0;
    int n_segerr = 0;

    display_scan_capture #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(1024)) dut1 (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .digits(digits1), .digit_valid(valid1), .digit_blank(blank1), .dp_lit(dpl1),
        .frame_done(frame1), .scan_error(scan1), .seg_error(segerr1), .stale(stale1)
    );

    display_scan_capture #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(1024)) dut3 (
        .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
        .digits(digits3), .digit_valid(valid3), .digit_blank(blank3), .dp_lit(dpl3),
        .frame_done(frame3), .scan_error(scan3), .seg_error(segerr3), .stale(stale3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the default build, sampled on the falling edge
    always @(negedge clk) begin
        if (frame1)  n_frame  <= n_frame + 1;
        if (scan1)   n_scan   <= n_scan + 1;
        if (segerr1) n_segerr <= n_segerr + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait for the next falling edge, then drive a new pin pattern
    task automatic apply(input logic [3:0] a, input logic [6:0] s, input logic d);
        @(negedge clk);
        an  = a;
        seg = s;
        dp  = d;
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        dp  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {digits1, valid1, blank1, dpl1, frame1, scan1, segerr1, stale1}, 32'h0);
        rst = 1'b0;

        // Full rotation, one cycle per digit
        apply(4'b1110, 7'h40, 1'b1);
        apply(4'b1101, 7'h79, 1'b1);
        apply(4'b1011, 7'h24, 1'b1);
        apply(4'b0111, 7'h30, 1'b1);
        apply(4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        check("frame_pulse_on", {31'd0, frame1}, 32'd1);
        @(negedge clk);
        check("frame_pulse_off", {31'd0, frame1}, 32'd0);
        check("rot_digits", {16'd0, digits1}, 32'h3210);
        check("rot_valid", {28'd0, valid1}, 32'hF);
        check("rot_frames", n_frame, 32'd1);

        // Long dwell: a single capture, no pulses
        apply(4'b1110, 7'h02, 1'b1);
        repeat (50) @(negedge clk);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        check("hold_digits", {16'd0, digits1}, 32'h3216);
        check("hold_frames", n_frame, 32'd1);
        check("hold_segerr", n_segerr, 32'd0);
        check("hold_scanerr", n_scan, 32'd0);

        // Two anodes low: one scan_error pulse, nothing captured
        apply(4'b1100, 7'h40, 1'b1);
        repeat (10) @(negedge clk);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        check("scan_pulses", n_scan, 32'd1);
        check("scan_digits", {16'd0, digits1}, 32'h3216);
        check("scan_valid", {28'd0, valid1}, 32'hF);
        repeat (10) @(negedge clk);
        check("idle_no_scan", n_scan, 32'd1);

        // Illegal segment code on digit 2, then blank on digit 2
        apply(4'b1011, 7'h55, 1'b1);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        check("segerr_pulses", n_segerr, 32'd1);
        check("segerr_valid", {28'd0, valid1}, 32'hB);
        check("segerr_digits", {16'd0, digits1}, 32'h3216);
        apply(4'b1011, 7'h7F, 1'b1);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        check("blank_mask", {28'd0, blank1}, 32'h4);
        check("blank_valid", {28'd0, valid1}, 32'hB);

        // Lit decimal point on digit 1, then digit 3 completes a frame
        apply(4'b1101, 7'h79, 1'b0);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        check("dp_lit", {28'd0, dpl1}, 32'h2);
        apply(4'b0111, 7'h30, 1'b1);
        apply(4'b1111, 7'h7F, 1'b1);
        @(negedge clk);
        check("frame2_pulse", {31'd0, frame1}, 32'd1);
        @(negedge clk);
        check("frame2_count", n_frame, 32'd2);

        // Timeout boundary: stale exactly 1024 cycles after the last capture
        repeat (1022) @(negedge clk);
        check("stale_before", {31'd0, stale1}, 32'd0);
        @(negedge clk);
        check("stale_set", {31'd0, stale1}, 32'd1);
        check("stale_valid", {28'd0, valid1}, 32'h0);

        // Resume: stale clears together with the first capture
        apply(4'b1110, 7'h40, 1'b1);
        apply(4'b1111, 7'h7F, 1'b1);
        check("stale_hold", {31'd0, stale1}, 32'd1);
        @(negedge clk);
        check("stale_clear", {31'd0, stale1}, 32'd0);
        check("resume_valid", {28'd0, valid1}, 32'h1);
        check("resume_digits", {16'd0, digits1}, 32'h3210);

        // Reset in the middle of a frame with dp lit
        apply(4'b1101, 7'h79, 1'b0);
        apply(4'b1011, 7'h24, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              {digits1, valid1, blank1, dpl1, frame1, scan1, segerr1, stale1}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postreset_digits", {16'd0, digits1}, 32'h0200);
        check("postreset_dp", {28'd0, dpl1}, 32'h4);

        // SETTLE_CYCLES=3 build: 2-cycle glitch ignored, 3-cycle dwell captured
        apply(4'b1111, 7'h7F, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        apply(4'b1110, 7'h40, 1'b1);
        @(negedge clk);
        apply(4'b1111, 7'h7F, 1'b1);
        repeat (6) @(negedge clk);
        check("s3_glitch_valid", {28'd0, valid3}, 32'h0);
        apply(4'b1101, 7'h79, 1'b1);
        repeat (2) @(negedge clk);
        apply(4'b1111, 7'h7F, 1'b1);
        check("s3_before_capture", {28'd0, valid3}, 32'h0);
        @(negedge clk);
        check("s3_valid", {28'd0, valid3}, 32'h2);
        check("s3_digits", {16'd0, digits3}, 32'h0010);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
